// File: rtl/icb_ram_slv.sv
// rtl/icb_ram_slv.sv - ICB target serving a byte-wide RAM window with buffered, in-order responses
// Out-of-window accesses respond with err=1; a credit counter bounds outstanding commands to the FIFO depth.
module icb_ram_slv #(
  parameter logic [15:0] MEM_BASE  = 16'h0000,
  parameter int          MEM_SIZE  = 4096,
  parameter int          RSP_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_icb_cmd_valid,
  output logic        i_icb_cmd_ready,
  input  logic        i_icb_cmd_read,
  input  logic [15:0] i_icb_cmd_addr,
  input  logic [7:0]  i_icb_cmd_wdata,
  output logic        i_icb_rsp_valid,
  input  logic        i_icb_rsp_ready,
  output logic        i_icb_rsp_err,
  output logic [7:0]  i_icb_rsp_rdata
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int PW = $clog2(RSP_DEPTH);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(RSP_DEPTH - 1);

  logic [CW-1:0] credit;
  logic          cmd_fire;
  logic          rsp_fire;

  logic [16:0]   diff;
  logic          hit;
  logic [AW-1:0] index;

  logic [7:0]    mem [MEM_SIZE];
  logic [7:0]    ram_q;

  logic          stg_valid;
  logic          stg_read;
  logic          stg_err;
  logic [7:0]    push_rdata;

  logic          fifo_err   [RSP_DEPTH];
  logic [7:0]    fifo_rdata [RSP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          not_empty;

  assign i_icb_cmd_ready = (credit != CREDIT_MAX);
  assign cmd_fire        = i_icb_cmd_valid & i_icb_cmd_ready;
  assign rsp_fire        = not_empty & i_icb_rsp_ready;

  // A 17-bit subtraction exposes the borrow, so addresses below the base never wrap into the window.
  assign diff  = {1'b0, i_icb_cmd_addr} - {1'b0, MEM_BASE};
  assign hit   = !diff[16] && ({1'b0, diff[15:0]} < 17'(MEM_SIZE));
  assign index = diff[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= '0;
    end else if (cmd_fire && !rsp_fire) begin
      credit <= credit + CW'(1);
    end else if (!cmd_fire && rsp_fire) begin
      credit <= credit - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_fire && hit) begin
      if (i_icb_cmd_read) begin
        ram_q <= mem[index];
      end else begin
        mem[index] <= i_icb_cmd_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_read  <= 1'b0;
      stg_err   <= 1'b0;
    end else begin
      stg_valid <= cmd_fire;
      stg_read  <= i_icb_cmd_read;
      stg_err   <= !hit;
    end
  end

  assign push_rdata = (stg_read && !stg_err) ? ram_q : 8'h00;

  // Payload storage needs no reset; the outputs are gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (stg_valid) begin
      fifo_err[wr_ptr]   <= stg_err;
      fifo_rdata[wr_ptr] <= push_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (stg_valid) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (rsp_fire) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      end
      if (stg_valid && !rsp_fire) begin
        count <= count + CW'(1);
      end else if (!stg_valid && rsp_fire) begin
        count <= count - CW'(1);
      end
    end
  end

  assign not_empty       = (count != '0);
  assign i_icb_rsp_valid = not_empty;
  assign i_icb_rsp_err   = not_empty & fifo_err[rd_ptr];
  assign i_icb_rsp_rdata = not_empty ? fifo_rdata[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_icb_ram_slv.sv
// tb/tb_icb_ram_slv.sv - directed and random self-checking bench for icb_ram_slv
module tb_icb_ram_slv;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic [7:0]  rsp_rdata;

  int checks   = 0;
  int failures = 0;

  logic        s_rv, s_re, s_cr, cmd_f, rsp_f;
  logic [7:0]  s_rd;

  icb_ram_slv #(.MEM_BASE(16'h0000), .MEM_SIZE(4096), .RSP_DEPTH(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_icb_cmd_valid (cmd_valid),
    .i_icb_cmd_ready (cmd_ready),
    .i_icb_cmd_read  (cmd_read),
    .i_icb_cmd_addr  (cmd_addr),
    .i_icb_cmd_wdata (cmd_wdata),
    .i_icb_rsp_valid (rsp_valid),
    .i_icb_rsp_ready (rsp_ready),
    .i_icb_rsp_err   (rsp_err),
    .i_icb_rsp_rdata (rsp_rdata)
  );

  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge: samples this cycle's outputs, applies inputs, advances one cycle.
  task automatic drive(input logic v, input logic rd, input logic [15:0] a,
                       input logic [7:0] wd, input logic rr);
    cmd_valid = v; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; rsp_ready = rr;
    s_rv = rsp_valid; s_re = rsp_err; s_rd = rsp_rdata; s_cr = cmd_ready;
    cmd_f = v && s_cr;
    rsp_f = rr && s_rv;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (rsp_rdata !== 8'h00) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=00", rsp_rdata); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b0, 16'h0010, 8'hA5, 1'b1);
    checks++; if (cmd_f !== 1'b1) begin failures++; $display("FAIL basic_wr_accept got=%b exp=1", cmd_f); end
    drive(1'b1, 1'b1, 16'h0010, 8'h00, 1'b1);
    checks++; if (s_rv !== 1'b0) begin failures++; $display("FAIL basic_latency1 rsp_valid got=%b exp=0", s_rv); end
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    checks++; if ({s_rv, s_re, s_rd} !== {1'b1, 1'b0, 8'h00}) begin
      failures++; $display("FAIL basic_wr_rsp got v=%b e=%b d=%h exp v=1 e=0 d=00", s_rv, s_re, s_rd); end
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    checks++; if ({s_rv, s_re, s_rd} !== {1'b1, 1'b0, 8'hA5}) begin
      failures++; $display("FAIL basic_rd_rsp got v=%b e=%b d=%h exp v=1 e=0 d=a5", s_rv, s_re, s_rd); end
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    checks++; if (s_rv !== 1'b0) begin failures++; $display("FAIL basic_idle rsp_valid got=%b exp=0", s_rv); end
  endtask

  task automatic test_errors();
    logic [15:0] ea [4] = '{16'h0FFF, 16'h1000, 16'hFFFF, 16'h0FFF};
    logic        er [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0]  ew [4] = '{8'h3C, 8'h00, 8'hC3, 8'h00};
    logic        xe [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0]  xd [4] = '{8'h00, 8'h00, 8'h00, 8'h3C};
    int issued = 0;
    int got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (issued < 4) drive(1'b1, er[issued], ea[issued], ew[issued], 1'b1);
      else            drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
      if (cmd_f) issued++;
      if (rsp_f) begin
        checks++;
        if ({s_re, s_rd} !== {xe[got], xd[got]}) begin
          failures++; $display("FAIL err_rsp%0d got e=%b d=%h exp e=%b d=%h", got, s_re, s_rd, xe[got], xd[got]); end
        got++;
      end
    end
    checks++; if (got !== 4) begin failures++; $display("FAIL err_rsp_count got=%0d exp=4", got); end
  endtask

  task automatic test_backpressure();
    int issued = 0;
    int got = 0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 16'(i), 8'(8'h50 + i), 1'b1);
    repeat (4) drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b1, 16'(issued), 8'h00, 1'b0);
      if (cmd_f) issued++;
    end
    checks++; if (issued !== 3) begin failures++; $display("FAIL bp_accepted got=%0d exp=3", issued); end
    checks++; if (s_cr !== 1'b0) begin failures++; $display("FAIL bp_cmd_ready_full got=%b exp=0", s_cr); end
    checks++; if ({s_rv, s_re, s_rd} !== {1'b1, 1'b0, 8'h50}) begin
      failures++; $display("FAIL bp_head_hold got v=%b e=%b d=%h exp v=1 e=0 d=50", s_rv, s_re, s_rd); end
    for (int c = 0; c < 20 && got < 5; c++) begin
      drive(issued < 5, 1'b1, 16'(issued), 8'h00, 1'b1);
      if (c == 0) begin
        checks++; if ({s_cr, rsp_f} !== 2'b01) begin
          failures++; $display("FAIL bp_release0 got ready=%b rspfire=%b exp ready=0 rspfire=1", s_cr, rsp_f); end
      end
      if (c == 1) begin
        checks++; if (s_cr !== 1'b1) begin failures++; $display("FAIL bp_release1 cmd_ready got=%b exp=1", s_cr); end
      end
      if (cmd_f) issued++;
      if (rsp_f) begin
        checks++;
        if ({s_re, s_rd} !== {1'b0, 8'(8'h50 + got)}) begin
          failures++; $display("FAIL bp_rsp%0d got e=%b d=%h exp e=0 d=%h", got, s_re, s_rd, 8'(8'h50 + got)); end
        got++;
      end
    end
    checks++; if (got !== 5) begin failures++; $display("FAIL bp_rsp_count got=%0d exp=5", got); end
  endtask

  task automatic test_back_to_back();
    int issued = 0;
    int got = 0;
    logic dropped = 1'b0;
    logic [7:0] ed;
    for (int c = 0; c < 60 && got < 32; c++) begin
      drive(issued < 32, issued >= 16, 16'(16'h0100 + (issued % 16)), 8'((issued % 16) * 7 + 3), 1'b1);
      if (issued < 32 && !s_cr) dropped = 1'b1;
      if (cmd_f) issued++;
      if (rsp_f) begin
        ed = (got < 16) ? 8'h00 : 8'((got - 16) * 7 + 3);
        checks++;
        if ({s_re, s_rd} !== {1'b0, ed}) begin
          failures++; $display("FAIL b2b_rsp%0d got e=%b d=%h exp e=0 d=%h", got, s_re, s_rd, ed); end
        got++;
      end
    end
    checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL b2b_cmd_ready_drop got=1 exp=0"); end
    checks++; if (got !== 32) begin failures++; $display("FAIL b2b_rsp_count got=%0d exp=32", got); end
  endtask

  task automatic test_reset_mid();
    logic stale = 1'b0;
    repeat (3) drive(1'b1, 1'b1, 16'h0001, 8'h00, 1'b0);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rmid_queued rsp_valid got=%b exp=1", rsp_valid); end
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_rsp_valid got=%b exp=0", rsp_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
      if (s_rv) stale = 1'b1;
    end
    checks++; if (s_cr !== 1'b1) begin failures++; $display("FAIL rmid_cmd_ready got=%b exp=1", s_cr); end
    checks++; if (stale !== 1'b0) begin failures++; $display("FAIL rmid_stale_rsp got=1 exp=0"); end
  endtask

  task automatic test_random();
    logic [7:0] model [4096];
    logic       known [4096];
    logic [9:0] q[$];
    logic [9:0] e;
    logic       v, rd, rr, hit;
    logic [15:0] a;
    logic [7:0] wd;
    logic       prev_stall = 1'b0;
    logic       prev_e = 1'b0;
    logic [7:0] prev_d = 8'h00;
    int issued = 0;
    int got = 0;
    int bad_order = 0;
    for (int i = 0; i < 4096; i++) known[i] = 1'b0;
    for (int c = 0; c < 4000 && (issued < 200 || q.size() != 0); c++) begin
      v  = (issued < 200) && ($urandom_range(3) != 0);
      rd = $urandom_range(1) == 1;
      a  = ($urandom_range(7) == 0) ? 16'($urandom) : 16'(16'h0FF0 + $urandom_range(31));
      wd = 8'($urandom);
      rr = (issued >= 200) || ($urandom_range(1) == 1);
      drive(v, rd, a, wd, rr);
      if (prev_stall) begin
        checks++;
        if ({s_rv, s_re, s_rd} !== {1'b1, prev_e, prev_d}) begin
          failures++; $display("FAIL rnd_hold got v=%b e=%b d=%h exp v=1 e=%b d=%h", s_rv, s_re, s_rd, prev_e, prev_d); end
      end
      prev_stall = s_rv && !rr; prev_e = s_re; prev_d = s_rd;
      if (rsp_f) begin
        if (q.size() == 0) bad_order++;
        else begin
          e = q.pop_front();
          checks++;
          if (s_re !== e[8] || (e[9] && s_rd !== e[7:0])) begin
            failures++; $display("FAIL rnd_rsp%0d got e=%b d=%h exp e=%b d=%h known=%b", got, s_re, s_rd, e[8], e[7:0], e[9]); end
        end
        got++;
      end
      if (cmd_f) begin
        hit = (a < 16'h1000);
        if (!rd && hit) begin model[a[11:0]] = wd; known[a[11:0]] = 1'b1; end
        if (rd && hit) q.push_back({known[a[11:0]], 1'b0, model[a[11:0]]});
        else           q.push_back({1'b1, !hit, 8'h00});
        issued++;
      end
    end
    checks++; if (bad_order !== 0) begin failures++; $display("FAIL rnd_unexpected_rsp got=%0d exp=0", bad_order); end
    checks++; if ({issued, got} !== {32'd200, 32'd200}) begin
      failures++; $display("FAIL rnd_counts got issued=%0d rsp=%0d exp 200/200", issued, got); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
